usb_crc_serializer: RTL and testbench

//   Generalised successor of the CRC5-only token encoder: one block that serialises PID, payload and CRC.

---
 rtl/usb_crc_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_usb_crc_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_serializer.sv
// USB packet body serializer: PID, payload and optional CRC5/CRC16 sent LSB-first
// with a valid/ready bit stream towards the bit-stuffer.
module usb_crc_serializer #(
  parameter  int unsigned MAX_BITS = 64,
  parameter  int unsigned PID_BITS = 8,
  localparam int unsigned LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PID_BITS-1:0] pid_in,
  input  logic [MAX_BITS-1:0] data_in,
  input  logic [LEN_W-1:0]    data_len,
  input  logic [1:0]          crc_mode,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                bit_out,
  output logic                bit_valid,
  input  logic                bit_ready,
  output logic                pkt_done,
  output logic                busy
);

  localparam int unsigned SPAN0 = (MAX_BITS > PID_BITS) ? MAX_BITS : PID_BITS;
  localparam int unsigned SPAN  = (SPAN0 > 16) ? SPAN0 : 16;
  localparam int unsigned CNT_W = $clog2(SPAN);

  localparam logic [CNT_W-1:0] PID_LAST   = CNT_W'(PID_BITS - 1);
  localparam logic [CNT_W-1:0] CRC5_LAST  = CNT_W'(4);
  localparam logic [CNT_W-1:0] CRC16_LAST = CNT_W'(15);

  typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_CRC} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PID_BITS-1:0]   pid_q, pid_d;
  logic [MAX_BITS-1:0]   data_q, data_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  crc5_q, crc5_d;
  logic                  crc16_q, crc16_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  bit_out_q, bit_out_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  pkt_done_q, pkt_done_d;

  logic                  take;
  logic                  crc_en;
  logic                  data_bit;
  logic [CNT_W-1:0]      data_last;
  logic [CNT_W-1:0]      crc_last;
  logic [CNT_W-1:0]      crc_last_d;
  logic [CNT_W-1:0]      crc_idx;

  function automatic logic [4:0] crc5_step(input logic [4:0] q, input logic b);
    logic fb;
    fb = q[4] ^ b;
    return {q[3], q[2], q[1] ^ fb, q[0], fb};
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] q, input logic b);
    logic fb;
    fb = q[15] ^ b;
    return {q[14] ^ fb, q[13:2], q[1] ^ fb, q[0], fb};
  endfunction

  assign in_ready  = in_ready_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign pkt_done  = pkt_done_q;
  assign busy      = busy_q;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pid_d       = pid_q;
    data_d      = data_q;
    len_d       = len_q;
    crc5_d      = crc5_q;
    crc16_d     = crc16_q;
    lfsr_d      = lfsr_q;
    pkt_done_d  = 1'b0;
    bit_out_d   = 1'b0;
    crc_last_d  = CRC5_LAST;
    crc_idx     = '0;

    take      = bit_valid_q & bit_ready;
    crc_en    = crc5_q | crc16_q;
    crc_last  = crc16_q ? CRC16_LAST : CRC5_LAST;
    data_last = CNT_W'(len_q - LEN_W'(1));
    data_bit  = |(data_q & (MAX_BITS'(1) << cnt_q));

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pid_d   = pid_in;
          data_d  = data_in;
          len_d   = (data_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : data_len;
          crc5_d  = (crc_mode == 2'b01);
          crc16_d = (crc_mode == 2'b10);
          lfsr_d  = '1;
          cnt_d   = '0;
          state_d = S_PID;
        end
      end
      S_PID: begin
        if (take) begin
          if (cnt_q == PID_LAST) begin
            cnt_d = '0;
            if (len_q != '0) begin
              state_d = S_DATA;
            end else if (crc_en) begin
              state_d = S_CRC;
            end else begin
              state_d    = S_IDLE;
              pkt_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (take) begin
          lfsr_d = crc16_q ? crc16_step(lfsr_q, data_bit)
                           : {lfsr_q[15:5], crc5_step(lfsr_q[4:0], data_bit)};
          if (cnt_q == data_last) begin
            cnt_d = '0;
            if (crc_en) begin
              state_d = S_CRC;
            end else begin
              state_d    = S_IDLE;
              pkt_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CRC: begin
        if (take) begin
          if (cnt_q == crc_last) begin
            cnt_d      = '0;
            state_d    = S_IDLE;
            pkt_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output bit is picked from the next-cycle state so it leaves a flop
    bit_valid_d = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    crc_last_d  = crc16_d ? CRC16_LAST : CRC5_LAST;
    crc_idx     = crc_last_d - cnt_d;
    unique case (state_d)
      S_PID:   bit_out_d = |(pid_d & (PID_BITS'(1) << cnt_d));
      S_DATA:  bit_out_d = |(data_d & (MAX_BITS'(1) << cnt_d));
      S_CRC:   bit_out_d = ~(|(lfsr_d & (16'(1) << crc_idx)));
      default: bit_out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pid_q       <= '0;
      data_q      <= '0;
      len_q       <= '0;
      crc5_q      <= 1'b0;
      crc16_q     <= 1'b0;
      lfsr_q      <= '1;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pid_q       <= pid_d;
      data_q      <= data_d;
      len_q       <= len_d;
      crc5_q      <= crc5_d;
      crc16_q     <= crc16_d;
      lfsr_q      <= lfsr_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Directed bench for usb_crc_serializer: token, data, handshake, clamp,
// stall, mid-packet reset and back-to-back packets.
module tb_usb_crc_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pid_in;
  logic [63:0] data_in;
  logic [6:0]  data_len;
  logic [1:0]  crc_mode;
  logic        in_valid;
  logic        in_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        pkt_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [127:0] rx_bits;
  int           rx_n;
  int           rx_done;
  int           rx_first;
  int           hold_bad;

  usb_crc_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .pid_in    (pid_in),
    .data_in   (data_in),
    .data_len  (data_len),
    .crc_mode  (crc_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .pkt_done  (pkt_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Polynomial-division reference: Galois shift with the generator constant
  function automatic logic [15:0] crc_feed(input logic [15:0] crc_in, input logic b, input int w);
    logic [15:0] poly;
    logic [15:0] mask;
    logic [15:0] crc;
    logic        fb;
    poly = (w == 16) ? 16'h8005 : 16'h0005;
    mask = (w == 16) ? 16'hFFFF : 16'h001F;
    crc  = crc_in;
    fb   = crc[w-1] ^ b;
    crc  = ((crc << 1) ^ (fb ? poly : 16'h0000)) & mask;
    return crc;
  endfunction

  function automatic logic [127:0] exp_bits(input logic [7:0] p, input logic [63:0] d,
                                            input int len, input int w);
    logic [127:0] v;
    logic [15:0]  crc;
    v   = '0;
    crc = (w == 16) ? 16'hFFFF : 16'h001F;
    for (int i = 0; i < 8; i++) v[i] = p[i];
    for (int i = 0; i < len; i++) begin
      v[8+i] = d[i];
      if (w > 0) crc = crc_feed(crc, d[i], w);
    end
    for (int i = 0; i < w; i++) v[8+len+i] = ~crc[w-1-i];
    return v;
  endfunction

  // Receiver-side check over payload plus received CRC
  function automatic logic [15:0] residual(input logic [127:0] bits, input int len, input int w);
    logic [15:0] crc;
    crc = (w == 16) ? 16'hFFFF : 16'h001F;
    for (int i = 0; i < len + w; i++) crc = crc_feed(crc, bits[8+i], w);
    return crc;
  endfunction

  task automatic send(input logic [7:0] p, input logic [63:0] d, input logic [6:0] l,
                      input logic [1:0] m);
    pid_in   = p;
    data_in  = d;
    data_len = l;
    crc_mode = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Gathers accepted bits until pkt_done; cycle 1 is the first after acceptance
  task automatic collect(input bit stall);
    logic prev_stall;
    logic prev_bit;
    rx_bits    = '0;
    rx_n       = 0;
    rx_done    = -1;
    rx_first   = -1;
    hold_bad   = 0;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      bit_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pkt_done) begin
        rx_done = c;
        break;
      end
      if (prev_stall && (bit_valid !== 1'b1 || bit_out !== prev_bit)) hold_bad++;
      if (bit_valid && bit_ready && rx_n < 128) begin
        if (rx_first < 0) rx_first = c;
        rx_bits[7'(rx_n)] = bit_out;
        rx_n++;
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      @(posedge clk); #1;
    end
    bit_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    pid_in    = '0;
    data_in   = '0;
    data_len  = '0;
    crc_mode  = '0;
    in_valid  = 1'b0;
    bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk_i("rst_in_ready", int'(in_ready), 1);
    chk_i("rst_bit_valid", int'(bit_valid), 0);
    chk_i("rst_bit_out", int'(bit_out), 0);
    chk_i("rst_pkt_done", int'(pkt_done), 0);
    chk_i("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Token IN with CRC5
    send(8'h69, 64'hFFFF_0000_0000_07F1, 7'd11, 2'b01);
    chk_i("tok_busy", int'(busy), 1);
    chk_i("tok_in_ready", int'(in_ready), 0);
    collect(1'b0);
    chk_i("tok_done_cycle", rx_done, 25);
    chk_i("tok_nbits", rx_n, 24);
    chk_v("tok_pid", 128'(rx_bits[7:0]), 128'(8'h69));
    chk_v("tok_bits", rx_bits, exp_bits(8'h69, 64'h7F1, 11, 5));
    chk_v("tok_residual", 128'(residual(rx_bits, 11, 5)), 128'(16'h000C));
    chk_i("tok_done_ready", int'(in_ready), 1);

    // Zero-length DATA0 with CRC16
    send(8'hC3, 64'h0, 7'd0, 2'b10);
    collect(1'b0);
    chk_i("zl_done_cycle", rx_done, 25);
    chk_i("zl_nbits", rx_n, 24);
    chk_v("zl_bits", rx_bits, 128'h0000_00C3);
    chk_v("zl_residual", 128'(residual(rx_bits, 0, 16)), 128'(16'h800D));

    // 64-bit DATA1 with random downstream stalls
    send(8'h4B, 64'hDEAD_BEEF_0123_4567, 7'd64, 2'b10);
    collect(1'b1);
    chk_i("d64_finished", int'(rx_done > 0), 1);
    chk_i("d64_nbits", rx_n, 88);
    chk_i("d64_hold", hold_bad, 0);
    chk_v("d64_bits", rx_bits, exp_bits(8'h4B, 64'hDEAD_BEEF_0123_4567, 64, 16));
    chk_v("d64_residual", 128'(residual(rx_bits, 64, 16)), 128'(16'h800D));

    // Handshake: PID only
    send(8'hD2, 64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 2'b00);
    collect(1'b0);
    chk_i("hs_done_cycle", rx_done, 9);
    chk_i("hs_nbits", rx_n, 8);
    chk_v("hs_bits", rx_bits, 128'hD2);

    // Length above MAX_BITS clamps to 64
    send(8'hC3, 64'h0F0F_1234_8000_0001, 7'd70, 2'b10);
    collect(1'b0);
    chk_i("clamp_done_cycle", rx_done, 89);
    chk_i("clamp_nbits", rx_n, 88);
    chk_v("clamp_bits", rx_bits, exp_bits(8'hC3, 64'h0F0F_1234_8000_0001, 64, 16));
    chk_v("clamp_residual", 128'(residual(rx_bits, 64, 16)), 128'(16'h800D));

    // Mode 11 sends no CRC
    send(8'h4B, 64'h5A, 7'd8, 2'b11);
    collect(1'b0);
    chk_i("m3_done_cycle", rx_done, 17);
    chk_i("m3_nbits", rx_n, 16);
    chk_v("m3_bits", rx_bits, 128'h5A4B);

    // Reset while payload bit 5 is on the wire
    send(8'hC3, 64'h1234, 7'd16, 2'b10);
    repeat (13) begin
      @(posedge clk); #1;
    end
    chk_i("mid_valid", int'(bit_valid), 1);
    chk_i("mid_bit5", int'(bit_out), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_i("mid_rst_valid", int'(bit_valid), 0);
    chk_i("mid_rst_ready", int'(in_ready), 1);
    chk_i("mid_rst_done", int'(pkt_done), 0);
    chk_i("mid_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk_i("mid_rst_done2", int'(pkt_done), 0);
    send(8'h69, 64'h2B5, 7'd11, 2'b01);
    collect(1'b0);
    chk_i("post_rst_nbits", rx_n, 24);
    chk_v("post_rst_bits", rx_bits, exp_bits(8'h69, 64'h2B5, 11, 5));
    chk_v("post_rst_residual", 128'(residual(rx_bits, 11, 5)), 128'(16'h000C));

    // Back-to-back: second request held high through the first packet
    send(8'hD2, 64'h0, 7'd0, 2'b00);
    pid_in   = 8'hE1;
    data_in  = 64'h155;
    data_len = 7'd11;
    crc_mode = 2'b01;
    in_valid = 1'b1;
    collect(1'b0);
    chk_i("b2b_first_done", rx_done, 9);
    chk_i("b2b_ready_in_done", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(1'b0);
    chk_i("b2b_no_gap", rx_first, 1);
    chk_i("b2b_nbits", rx_n, 24);
    chk_v("b2b_pid", 128'(rx_bits[7:0]), 128'(8'hE1));
    chk_v("b2b_bits", rx_bits, exp_bits(8'hE1, 64'h155, 11, 5));
    chk_v("b2b_residual", 128'(residual(rx_bits, 11, 5)), 128'(16'h000C));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
